// File: rtl/stall_unit.sv
// stall_unit: pipeline hazard detector for a MIPS-style core.
//   Detects load-use hazards against the instruction in EX and mult/div
//   hazards against a multi-cycle HI/LO unit, and tracks HI/LO occupancy.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   id_rs, id_rt            source register fields of the instruction in ID
//   id_use_rs, id_use_rt    ID instruction actually reads rs / rt
//   id_use_md               ID instruction touches HI/LO (mult/div/mfhi/mflo/mthi/mtlo)
//   ex_mem_read, ex_rd      EX instruction is a load, and its destination
//   md_start, md_is_div     mult/div issuing in EX this cycle, and which kind
//   OR1_out                 stall: hold PC and IF/ID, bubble ID/EX
//   md_busy                 HI/LO unit occupied
//   stall_cnt               number of stalled cycles since reset
//
// Parameters
//   MULT_LAT, DIV_LAT       busy cycles after issue (1..15)
//
// Configuration macro
//   STALL_UNIT_STALL_CNT_EN  defined: stall_cnt is a saturating counter
//                            undefined: stall_cnt is tied to zero
//
// FSM
//   state | meaning
//   IDLE  | HI/LO unit free, cnt == 0
//   BUSY  | mult/div in flight, cnt = busy cycles remaining (>= 1)
module stall_unit #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_use_md,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        md_start,
  input  logic        md_is_div,
  output logic        OR1_out,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       lu, mh;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (md_start) begin
      // A new issue always (re)loads the latency, also while BUSY.
      state_nxt = BUSY;
      cnt_nxt   = md_is_div ? DIV_CNT : MULT_CNT;
    end else begin
      case (state)
        IDLE: cnt_nxt = 4'd0;
        BUSY: begin
          // cnt <= 1 rather than == 1 so the counter can never wrap.
          if (cnt <= 4'd1) begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  assign md_busy = (state == BUSY);

  assign lu = ex_mem_read && (ex_rd != 5'd0) &&
              ((id_use_rs && (ex_rd == id_rs)) || (id_use_rt && (ex_rd == id_rt)));

  // While reset is held the occupancy is already considered gone, even in
  // the first reset cycle where the registered md_busy is still high.
  assign mh = id_use_md && (md_start || (md_busy && !reset));

  assign OR1_out = lu || mh;

`ifdef STALL_UNIT_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= 32'h0;
    end else if (OR1_out && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_stall_unit.sv
// Self-checking bench for stall_unit (default MULT_LAT=5, DIV_LAT=10).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Expected values are queued when a cycle is driven and
// popped when that cycle's outputs are sampled.
module tb_stall_unit;

`ifdef STALL_UNIT_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_use_rs, id_use_rt, id_use_md;
  logic        ex_mem_read, md_start, md_is_div;
  logic        OR1_out, md_busy;
  logic [31:0] stall_cnt;

  typedef struct packed {
    logic or1;
    logic busy;
    logic rst;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] model_stall;
  logic [31:0] exp_sc;
  int          checks;
  int          errors;

  stall_unit dut (
    .clock       (clock),
    .reset       (reset),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_use_md   (id_use_md),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .md_start    (md_start),
    .md_is_div   (md_is_div),
    .OR1_out     (OR1_out),
    .md_busy     (md_busy),
    .stall_cnt   (stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drv(input logic rst, input logic ms, input logic dv, input logic umd,
                     input logic mr, input logic [4:0] rd, input logic [4:0] rs,
                     input logic [4:0] rt, input logic urs, input logic urt);
    reset       = rst;
    md_start    = ms;
    md_is_div   = dv;
    id_use_md   = umd;
    ex_mem_read = mr;
    ex_rd       = rd;
    id_rs       = rs;
    id_rt       = rt;
    id_use_rs   = urs;
    id_use_rt   = urt;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Stall-count reference: cleared by reset, +1 per stalled non-reset edge.
  task automatic update_model(input exp_t x);
    if (x.rst) model_stall = 32'h0;
    else if (x.or1 && model_stall != 32'hFFFF_FFFF) model_stall = model_stall + 32'd1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_q.push_back('{1'b0, 1'b0, 1'b1}); end
        1: begin drv(1, 0, 0, 0, 1, 8, 8, 0, 1, 0); exp_q.push_back('{1'b1, 1'b0, 1'b1}); end
        2: begin drv(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); exp_q.push_back('{1'b0, 1'b0, 1'b1}); end
        default: begin drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_q.push_back('{1'b0, 1'b0, 1'b0}); end
      endcase
      @(negedge clock);
      e = exp_q.pop_front();
      exp_sc = CNT_EN ? model_stall : 32'h0;
      checks++;
      if (OR1_out !== e.or1) begin errors++; $display("FAIL reset_or1 k=%0d got %b want %b", k, OR1_out, e.or1); end
      checks++;
      if (md_busy !== e.busy) begin errors++; $display("FAIL reset_busy k=%0d got %b want %b", k, md_busy, e.busy); end
      checks++;
      if (stall_cnt !== exp_sc) begin errors++; $display("FAIL reset_stall_cnt k=%0d got %0d want %0d", k, stall_cnt, exp_sc); end
      update_model(e);
      next_cycle();
    end
  endtask

  typedef struct packed {
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       hz;
  } lu_row_t;

  task automatic test_load_use();
    lu_row_t rows[8];
    rows[0] = '{1'b1, 5'd8,  5'd8,  5'd0,  1'b1, 1'b0, 1'b1};
    rows[1] = '{1'b1, 5'd0,  5'd8,  5'd0,  1'b1, 1'b0, 1'b0};
    rows[2] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0};
    rows[3] = '{1'b1, 5'd5,  5'd1,  5'd5,  1'b0, 1'b1, 1'b1};
    rows[4] = '{1'b1, 5'd5,  5'd1,  5'd5,  1'b0, 1'b0, 1'b0};
    rows[5] = '{1'b0, 5'd8,  5'd8,  5'd0,  1'b1, 1'b0, 1'b0};
    rows[6] = '{1'b1, 5'd9,  5'd8,  5'd9,  1'b1, 1'b0, 1'b0};
    rows[7] = '{1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 8; k++) begin
      drv(0, 0, 0, 0, rows[k].mr, rows[k].rd, rows[k].rs, rows[k].rt, rows[k].urs, rows[k].urt);
      exp_q.push_back('{rows[k].hz, 1'b0, 1'b0});
      @(negedge clock);
      e = exp_q.pop_front();
      exp_sc = CNT_EN ? model_stall : 32'h0;
      checks++;
      if (OR1_out !== e.or1) begin errors++; $display("FAIL load_use_or1 row=%0d got %b want %b", k, OR1_out, e.or1); end
      checks++;
      if (md_busy !== e.busy) begin errors++; $display("FAIL load_use_busy row=%0d got %b want %b", k, md_busy, e.busy); end
      checks++;
      if (stall_cnt !== exp_sc) begin errors++; $display("FAIL load_use_stall_cnt row=%0d got %0d want %0d", k, stall_cnt, exp_sc); end
      update_model(e);
      next_cycle();
    end
  endtask

  // Mult issued at k=0 with id_use_md held: busy k=1..5, stall k=0..5.
  task automatic test_mult();
    for (int k = 0; k < 8; k++) begin
      drv(0, (k == 0), 0, 1, 0, 0, 0, 0, 0, 0);
      exp_q.push_back('{(k <= 5), (k >= 1 && k <= 5), 1'b0});
      @(negedge clock);
      e = exp_q.pop_front();
      exp_sc = CNT_EN ? model_stall : 32'h0;
      checks++;
      if (OR1_out !== e.or1) begin errors++; $display("FAIL mult_or1 k=%0d got %b want %b", k, OR1_out, e.or1); end
      checks++;
      if (md_busy !== e.busy) begin errors++; $display("FAIL mult_busy k=%0d got %b want %b", k, md_busy, e.busy); end
      checks++;
      if (stall_cnt !== exp_sc) begin errors++; $display("FAIL mult_stall_cnt k=%0d got %0d want %0d", k, stall_cnt, exp_sc); end
      update_model(e);
      next_cycle();
    end
  endtask

  // Div issued at k=0, no HI/LO user in ID: busy k=1..10, never stall.
  task automatic test_div();
    for (int k = 0; k < 13; k++) begin
      drv(0, (k == 0), 1, 0, 0, 0, 0, 0, 0, 0);
      exp_q.push_back('{1'b0, (k >= 1 && k <= 10), 1'b0});
      @(negedge clock);
      e = exp_q.pop_front();
      exp_sc = CNT_EN ? model_stall : 32'h0;
      checks++;
      if (OR1_out !== e.or1) begin errors++; $display("FAIL div_or1 k=%0d got %b want %b", k, OR1_out, e.or1); end
      checks++;
      if (md_busy !== e.busy) begin errors++; $display("FAIL div_busy k=%0d got %b want %b", k, md_busy, e.busy); end
      checks++;
      if (stall_cnt !== exp_sc) begin errors++; $display("FAIL div_stall_cnt k=%0d got %0d want %0d", k, stall_cnt, exp_sc); end
      update_model(e);
      next_cycle();
    end
  endtask

  // Div at k=0, mult re-issued in the 4th busy cycle (k=4): busy k=1..9.
  task automatic test_back_to_back();
    for (int k = 0; k < 12; k++) begin
      drv(0, (k == 0 || k == 4), (k == 0), 0, 0, 0, 0, 0, 0, 0);
      exp_q.push_back('{1'b0, (k >= 1 && k <= 9), 1'b0});
      @(negedge clock);
      e = exp_q.pop_front();
      exp_sc = CNT_EN ? model_stall : 32'h0;
      checks++;
      if (OR1_out !== e.or1) begin errors++; $display("FAIL restart_or1 k=%0d got %b want %b", k, OR1_out, e.or1); end
      checks++;
      if (md_busy !== e.busy) begin errors++; $display("FAIL restart_busy k=%0d got %b want %b", k, md_busy, e.busy); end
      checks++;
      if (stall_cnt !== exp_sc) begin errors++; $display("FAIL restart_stall_cnt k=%0d got %0d want %0d", k, stall_cnt, exp_sc); end
      update_model(e);
      next_cycle();
    end
  endtask

  // Mult issue and a load-use hazard in the same cycle: stall from the
  // load, and the HI/LO unit still goes busy for 5 cycles.
  task automatic test_concurrent();
    for (int k = 0; k < 7; k++) begin
      if (k == 0) drv(0, 1, 0, 0, 1, 12, 0, 12, 0, 1);
      else        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      exp_q.push_back('{(k == 0), (k >= 1 && k <= 5), 1'b0});
      @(negedge clock);
      e = exp_q.pop_front();
      exp_sc = CNT_EN ? model_stall : 32'h0;
      checks++;
      if (OR1_out !== e.or1) begin errors++; $display("FAIL concurrent_or1 k=%0d got %b want %b", k, OR1_out, e.or1); end
      checks++;
      if (md_busy !== e.busy) begin errors++; $display("FAIL concurrent_busy k=%0d got %b want %b", k, md_busy, e.busy); end
      checks++;
      if (stall_cnt !== exp_sc) begin errors++; $display("FAIL concurrent_stall_cnt k=%0d got %0d want %0d", k, stall_cnt, exp_sc); end
      update_model(e);
      next_cycle();
    end
  endtask

  // Div at k=0 with id_use_md held; reset during the 4th busy cycle (k=4,
  // id_use_md dropped there). From k=5 the unit is idle and nothing stalls.
  task automatic test_reset_abort();
    for (int k = 0; k < 8; k++) begin
      if (k == 4) drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      else        drv(0, (k == 0), 1, 1, 0, 0, 0, 0, 0, 0);
      exp_q.push_back('{(k <= 3), (k >= 1 && k <= 4), (k == 4)});
      @(negedge clock);
      e = exp_q.pop_front();
      exp_sc = CNT_EN ? model_stall : 32'h0;
      checks++;
      if (OR1_out !== e.or1) begin errors++; $display("FAIL abort_or1 k=%0d got %b want %b", k, OR1_out, e.or1); end
      checks++;
      if (md_busy !== e.busy) begin errors++; $display("FAIL abort_busy k=%0d got %b want %b", k, md_busy, e.busy); end
      checks++;
      if (stall_cnt !== exp_sc) begin errors++; $display("FAIL abort_stall_cnt k=%0d got %0d want %0d", k, stall_cnt, exp_sc); end
      update_model(e);
      next_cycle();
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    model_stall = 32'h0;
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    test_reset();
    test_load_use();
    test_mult();
    test_div();
    test_back_to_back();
    test_concurrent();
    test_reset_abort();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
